// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard unit for a 5-stage in-order core.
//   - Operand forwarding: fwd_a/fwd_b select the youngest matching writer
//     (source 1 = EX/MEM ... source NSRC = oldest), or 0 for the register file.
//   - Stall/flush FSM: RUN, LU_STALL (load-use bubbles), MEM_WAIT (data memory
//     busy), FLUSH (taken branch).
// Ports:
//   CLK, nRST               clock, async active-low reset
//   rs_id, rt_id            ID-stage source registers
//   rs_ex, rt_ex            EX-stage source registers
//   ex_dREN, ex_wsel        EX instruction is a load / its destination
//   src_wsel, src_regwrite  forwarding-source destinations / write enables
//   mem_req, dhit           MEM-stage request / data memory completion
//   br_taken                taken branch or jump this cycle
//   fwd_a, fwd_b            operand selects
//   pc_en..exmem_en         pipeline-register enables
//   ifid_flush, idex_flush  bubble inserts
//   stall_cnt               saturating count of cycles with pc_en=0
//   state                   FSM state (debug)

// One forwarding source: does it write a register that EX reads?
module hazard_fwd_match #(
   parameter int REGW = 5
) (
   input  logic [REGW-1:0] wsel,
   input  logic            regwrite,
   input  logic [REGW-1:0] rs,
   input  logic [REGW-1:0] rt,
   output logic            hit_a,
   output logic            hit_b
);
   // Register 0 is hardwired to zero and is never forwarded.
   assign hit_a = regwrite && (wsel == rs) && (rs != '0);
   assign hit_b = regwrite && (wsel == rt) && (rt != '0);
endmodule

module hazard_ctrl #(
   parameter int REGW       = 5,
   parameter int NSRC       = 2,
   parameter int LU_BUBBLES = 1,
   parameter int CNTW       = 16
) (
   input  logic                         CLK,
   input  logic                         nRST,
   input  logic [REGW-1:0]              rs_id,
   input  logic [REGW-1:0]              rt_id,
   input  logic [REGW-1:0]              rs_ex,
   input  logic [REGW-1:0]              rt_ex,
   input  logic                         ex_dREN,
   input  logic [REGW-1:0]              ex_wsel,
   input  logic [NSRC*REGW-1:0]         src_wsel,
   input  logic [NSRC-1:0]              src_regwrite,
   input  logic                         mem_req,
   input  logic                         dhit,
   input  logic                         br_taken,
   output logic [$clog2(NSRC+1)-1:0]    fwd_a,
   output logic [$clog2(NSRC+1)-1:0]    fwd_b,
   output logic                         pc_en,
   output logic                         ifid_en,
   output logic                         idex_en,
   output logic                         exmem_en,
   output logic                         ifid_flush,
   output logic                         idex_flush,
   output logic [CNTW-1:0]              stall_cnt,
   output logic [1:0]                   state
);
   localparam int FW   = $clog2(NSRC+1);
   localparam int BUBW = 2;

   typedef enum logic [1:0] {RUN = 2'd0, LU_STALL = 2'd1, MEM_WAIT = 2'd2, FLUSH = 2'd3} state_t;

   state_t            st;
   logic [BUBW-1:0]   bub;
   logic [NSRC-1:0]   hit_a, hit_b;
   logic              mem_wait, load_use, lu_hold;

   // ---------------- forwarding ----------------
   for (genvar i = 0; i < NSRC; i++) begin : g_src
      hazard_fwd_match #(.REGW(REGW)) u_match (
         .wsel     (src_wsel[i*REGW +: REGW]),
         .regwrite (src_regwrite[i]),
         .rs       (rs_ex),
         .rt       (rt_ex),
         .hit_a    (hit_a[i]),
         .hit_b    (hit_b[i])
      );
   end

   // Scan oldest to youngest so the youngest match wins.
   always_comb begin
      fwd_a = '0;
      fwd_b = '0;
      for (int i = NSRC-1; i >= 0; i--) begin
         if (hit_a[i]) fwd_a = FW'(i+1);
         if (hit_b[i]) fwd_b = FW'(i+1);
      end
   end

   // ---------------- hazard detection ----------------
   assign mem_wait = mem_req && !dhit;
   assign load_use = ex_dREN && (ex_wsel != '0) &&
                     ((ex_wsel == rs_id) || (ex_wsel == rt_id));
   // The detecting RUN cycle is the first bubble; LU_STALL supplies the rest.
   assign lu_hold  = ((st == RUN) && load_use) || (st == LU_STALL);

   always_comb begin
      pc_en      = 1'b1;
      ifid_en    = 1'b1;
      idex_en    = 1'b1;
      exmem_en   = 1'b1;
      ifid_flush = 1'b0;
      idex_flush = 1'b0;
      if (mem_wait) begin
         // Freeze everything; a branch resolving now is replayed after the wait.
         pc_en    = 1'b0;
         ifid_en  = 1'b0;
         idex_en  = 1'b0;
         exmem_en = 1'b0;
      end else if (br_taken) begin
         ifid_flush = 1'b1;
         idex_flush = 1'b1;
      end else if (lu_hold) begin
         pc_en      = 1'b0;
         ifid_en    = 1'b0;
         idex_flush = 1'b1;
      end
   end

   // ---------------- state ----------------
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         st        <= RUN;
         bub       <= '0;
         stall_cnt <= '0;
      end else begin
         if (!pc_en && (stall_cnt != {CNTW{1'b1}}))
            stall_cnt <= stall_cnt + 1'b1;

         if (mem_wait) begin
            st <= MEM_WAIT;
         end else if (br_taken) begin
            st <= FLUSH;
         end else if ((st == RUN) && load_use) begin
            // bub = bubbles still owed after the detecting cycle; a single
            // bubble is fully covered by the detecting cycle itself.
            bub <= BUBW'(LU_BUBBLES - 1);
            st  <= (LU_BUBBLES > 1) ? LU_STALL : RUN;
         end else if (st == LU_STALL) begin
            bub <= bub - 1'b1;
            st  <= (bub > BUBW'(1)) ? LU_STALL : RUN;
         end else begin
            st <= RUN;
         end
      end
   end

   assign state = st;
endmodule
